// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT issue sequencer:
//   - state_t       : sequencer FSM states (IDLE, ISSUE, FLUSH, DONE)
//   - DEFAULT_*     : default transform size / flush latency and the
//                     log2N / half-N widths derived from them
//   - log2n/half_n  : width helpers for an arbitrary power-of-two N
//   - flush_width   : width of the stage-barrier flush counter for a LAT
// No ports (package).
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_N      = 8;
  localparam int unsigned DEFAULT_LAT    = 4;
  localparam int unsigned DEFAULT_LOG2N  = $clog2(DEFAULT_N);
  localparam int unsigned DEFAULT_HALF_N = DEFAULT_N / 2;

  function automatic int unsigned log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned half_n(input int unsigned n);
    return n / 2;
  endfunction

  // A LAT of 1 still needs a one-bit counter that simply sits at zero.
  function automatic int unsigned flush_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/fft_twiddle_index.sv
// ---------------------------------------------------------------------------
// fft_twiddle_index
// Derives the twiddle exponent k (for W_N^k) of a radix-2 butterfly from the
// stage index and the pair index: the pair index with its low
// (log2N-1-stage) bits cleared. Purely combinational.
// Ports:
//   stage        in  [SW-1:0]  stage index, 0..log2N-1
//   pair_id      in  [PW-1:0]  butterfly pair, 0..N/2-1
//   twiddle_idx  out [PW-1:0]  twiddle exponent
// ---------------------------------------------------------------------------
module fft_twiddle_index #(
  parameter int unsigned SW = 3,
  parameter int unsigned PW = 2
) (
  input  logic [SW-1:0] stage,
  input  logic [PW-1:0] pair_id,
  output logic [PW-1:0] twiddle_idx
);

  logic [PW-1:0] keep_mask;

  // Shifting an all-ones word left by (PW - stage) leaves ones only in the
  // bits that survive; at stage 0 the shift equals the width and the mask
  // is all zeros, at the last stage the shift is 0 and the mask is all ones.
  assign keep_mask   = {PW{1'b1}} << (SW'(PW) - stage);
  assign twiddle_idx = pair_id & keep_mask;

endmodule

// File: rtl/fft_sequencer.sv
// ---------------------------------------------------------------------------
// fft_sequencer
// Walks a radix-2 FFT: for each of log2N stages it issues N/2 butterfly
// pairs (one per cycle while ready is high), then waits LAT cycles so the
// downstream pipeline drains before the next stage reads its results.
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a transform (sampled only in IDLE)
//   ready        in   downstream accepts the current issue
//   valid        out  stage/pair_id/twiddle_idx carry an issue
//   stage        out  [log2N-1:0]  stage index
//   pair_id      out  [log2N-2:0]  butterfly pair
//   twiddle_idx  out  [log2N-2:0]  twiddle exponent
//   last         out  final pair of the final stage
//   busy         out  transform in progress (ISSUE, FLUSH, DONE)
//   done         out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module fft_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N   = DEFAULT_N,
  parameter  int unsigned LAT = DEFAULT_LAT,
  localparam int unsigned SW  = log2n(N),
  localparam int unsigned PW  = SW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [SW-1:0] stage,
  output logic [PW-1:0] pair_id,
  output logic [PW-1:0] twiddle_idx,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   CW         = flush_width(LAT);
  localparam logic [SW-1:0] LAST_STAGE = SW'(SW - 1);
  localparam logic [PW-1:0] LAST_PAIR  = PW'(half_n(N) - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(LAT - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [PW-1:0] pair_q,  pair_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [PW-1:0] tw_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
    end
  end

  // The flush counter is loaded with LAT-1 and FLUSH exits on the cycle it
  // reads zero, which gives exactly LAT cycles with valid low.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          pair_d  = '0;
        end
      end
      ISSUE: begin
        if (ready) begin
          if (pair_q == LAST_PAIR) begin
            pair_d  = '0;
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end else begin
            pair_d = pair_q + PW'(1);
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + SW'(1);
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        stage_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fft_twiddle_index #(
    .SW(SW),
    .PW(PW)
  ) u_twiddle (
    .stage      (stage_q),
    .pair_id    (pair_q),
    .twiddle_idx(tw_raw)
  );

  // Issue fields are forced to zero whenever no issue is presented so the
  // downstream never sees stale indices.
  assign valid       = (state_q == ISSUE);
  assign stage       = valid ? stage_q : '0;
  assign pair_id     = valid ? pair_q  : '0;
  assign twiddle_idx = valid ? tw_raw  : '0;
  assign last        = valid && (stage_q == LAST_STAGE) && (pair_q == LAST_PAIR);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule
